// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse on the open-drain wire
// with the 80/80 us preamble and a 40-bit frame snapshotted from the byte inputs.
//   state     | meaning
//   IDLE      | line released, waiting for host low
//   HOST_LOW  | timing the host start pulse
//   RESP_WAIT | bytes captured, gap before answering
//   RESP_LOW  | preamble low (80 us)
//   RESP_HIGH | preamble high (80 us)
//   BIT_LOW   | 50 us low lead-in of each bit
//   BIT_HIGH  | high time encodes the bit value
//   END_LOW   | trailing 50 us low, then back to IDLE
module dht11_responder #(
  parameter int CLK_FREQ_MHZ  = 50,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic       clock,
  input  logic       reset_n,
  inout  wire        transmission_line,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temperature_int,
  input  logic [7:0] temperature_dec,
  input  logic       inject_error,
  output logic       busy,
  output logic       frame_done
);

  localparam int PW     = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam int MAX_US = START_MIN_US + RESP_DELAY_US + BIT0_HIGH_US + BIT1_HIGH_US + 80;
  localparam int CW     = $clog2(MAX_US + 1);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t          state, state_nx;
  logic            line_meta, line_sync;
  logic [PW-1:0]   presc;
  logic            us_tick;
  logic [CW-1:0]   us_cnt, us_limit, phase_len;
  logic            phase_end;
  logic [5:0]      bit_idx;
  logic [39:0]     frame;
  logic [7:0]      checksum;
  logic            drive_low;

  // Reset value 1 matches the idle pulled-up line, so release never looks like a start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_meta <= 1'b1;
      line_sync <= 1'b1;
    end else begin
      line_meta <= transmission_line;
      line_sync <= line_meta;
    end
  end

  assign us_tick  = (presc == PW'(CLK_FREQ_MHZ - 1));
  assign checksum = (humidity_int + humidity_dec + temperature_int + temperature_dec)
                    ^ {7'd0, inject_error};

  always_comb begin
    phase_len = '1;
    case (state)
      RESP_WAIT:           phase_len = CW'(RESP_DELAY_US);
      RESP_LOW, RESP_HIGH: phase_len = CW'(80);
      BIT_LOW, END_LOW:    phase_len = CW'(50);
      BIT_HIGH:            phase_len = frame[bit_idx] ? CW'(BIT1_HIGH_US) : CW'(BIT0_HIGH_US);
      default:             phase_len = '1;
    endcase
  end

  assign phase_end = us_tick && (us_cnt == phase_len - CW'(1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!line_sync) state_nx = HOST_LOW;
      HOST_LOW:  if (line_sync)
                   state_nx = (us_cnt >= CW'(START_MIN_US)) ? RESP_WAIT : IDLE;
      RESP_WAIT: if (phase_end) state_nx = RESP_LOW;
      RESP_LOW:  if (phase_end) state_nx = RESP_HIGH;
      RESP_HIGH: if (phase_end) state_nx = BIT_LOW;
      BIT_LOW:   if (phase_end) state_nx = BIT_HIGH;
      BIT_HIGH:  if (phase_end) state_nx = (bit_idx != 6'd0) ? BIT_LOW : END_LOW;
      END_LOW:   if (phase_end) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  assign us_limit = (state == HOST_LOW) ? CW'(START_MIN_US) : '1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      presc      <= '0;
      us_cnt     <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= (state == END_LOW) && (state_nx == IDLE);
      // Timebase restarts on every state entry so each phase is an exact multiple of 1 us.
      if (state_nx != state) begin
        presc  <= '0;
        us_cnt <= '0;
      end else begin
        presc <= us_tick ? '0 : presc + PW'(1);
        if (us_tick && (us_cnt != us_limit)) us_cnt <= us_cnt + CW'(1);
      end
      if (state == HOST_LOW && state_nx == RESP_WAIT)
        frame <= {humidity_int, humidity_dec, temperature_int, temperature_dec, checksum};
      if (state == RESP_HIGH && state_nx == BIT_LOW)
        bit_idx <= 6'd39;
      else if (state == BIT_HIGH && state_nx == BIT_LOW)
        bit_idx <= bit_idx - 6'd1;
    end
  end

  assign busy      = (state != IDLE) && (state != HOST_LOW);
  assign drive_low = (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);

  assign transmission_line = drive_low ? 1'b0 : 1'bz;

endmodule
